// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder slice.
// Contents:
//   ST_W / ST_IDLE / ST_SHIFT / ST_DONE : FSM state width and encodings.
//     The unused code ST_DONE+1 is treated as illegal and recovers to IDLE.
//   DEFAULT_WIDTH                       : default operand width.
package serial_adder_pkg;

  localparam int ST_W = 2;

  localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [ST_W-1:0] ST_SHIFT = 2'd1;
  localparam logic [ST_W-1:0] ST_DONE  = 2'd2;

  localparam int DEFAULT_WIDTH = 8;

endpackage : serial_adder_pkg

// File: rtl/half_adder.sv
// Half adder cell. It is the building block reused by the serial adder's
// full-adder cell.
// Ports:
//   a, b : input bits
//   s    : sum bit   (a ^ b)
//   c    : carry bit (a & b)
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule : half_adder

// File: rtl/serial_adder_full_adder.sv
// Full-adder cell for the serial adder. It is built from two half adders
// and an OR gate. The two half-adder carries can never both be 1, so an
// OR is enough to merge them.
// Ports:
//   a, b : operand bits
//   cin  : carry in
//   s    : sum bit
//   c    : carry out (majority of a, b, cin)
module serial_adder_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic c
);

  logic s0;
  logic c0;
  logic c1;

  half_adder u_ha0 (
    .a (a),
    .b (b),
    .s (s0),
    .c (c0)
  );

  half_adder u_ha1 (
    .a (s0),
    .b (cin),
    .s (s),
    .c (c1)
  );

  assign c = c0 | c1;

endmodule : serial_adder_full_adder

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder.
// The block accepts a, b and cin over a valid/ready handshake. It adds the
// operands LSB-first, one bit per clock, through a single full-adder cell
// with a registered carry. It then holds sum/cout on an output handshake
// until the consumer accepts them.
// Ports:
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset (released synchronously upstream)
//   in_valid  : a/b/cin valid
//   in_ready  : high only in IDLE
//   a, b      : WIDTH-bit addends
//   cin       : carry in
//   out_valid : high only in DONE
//   out_ready : consumer accepts result
//   sum       : (a + b + cin) mod 2^WIDTH; holds its value until the next completion
//   cout      : carry out of bit WIDTH-1
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [ST_W-1:0]  state_reg;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-1:0] sum_sh_reg;
  logic             carry_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;

  logic             bit_s;
  logic             bit_c;
  logic [WIDTH-1:0] sum_sh_next;

  serial_adder_full_adder u_fa (
    .a   (a_sh_reg[0]),
    .b   (b_sh_reg[0]),
    .cin (carry_reg),
    .s   (bit_s),
    .c   (bit_c)
  );

  // New sum bits enter at the MSB. After WIDTH shifts, the first bit that
  // entered (the LSB of the result) has reached bit 0.
  generate
    if (WIDTH == 1) begin : g_sum_w1
      assign sum_sh_next = bit_s;
    end else begin : g_sum_wn
      assign sum_sh_next = {bit_s, sum_sh_reg[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      count_reg  <= '0;
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      sum_sh_reg <= '0;
      carry_reg  <= 1'b0;
      sum_reg    <= '0;
      cout_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            a_sh_reg   <= a;
            b_sh_reg   <= b;
            carry_reg  <= cin;
            sum_sh_reg <= '0;
            count_reg  <= '0;
            state_reg  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          a_sh_reg   <= a_sh_reg >> 1;
          b_sh_reg   <= b_sh_reg >> 1;
          sum_sh_reg <= sum_sh_next;
          carry_reg  <= bit_c;
          count_reg  <= count_reg + CW'(1);
          if (count_reg == LAST) begin
            sum_reg   <= sum_sh_next;
            cout_reg  <= bit_c;
            state_reg <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          // The unused encoding recovers to IDLE.
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // Handshake flags come only from registered state, so there is no
  // combinational path from any input to any output.
  assign in_ready  = (state_reg == ST_IDLE);
  assign out_valid = (state_reg == ST_DONE);
  assign sum       = sum_reg;
  assign cout      = cout_reg;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder: WIDTH=8 directed tests plus exhaustive WIDTH=4
// and WIDTH=1 runs, all checked against scoreboard queues.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- WIDTH = 8 ----------------
  logic       rst_n, in_valid, in_ready, out_valid, out_ready, cin, cout;
  logic [7:0] a, b, sum;
  logic [8:0] sb8[$];

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
  );

  // ---------------- WIDTH = 4 ----------------
  logic       rst_n4, in_valid4, in_ready4, out_valid4, out_ready4, cin4, cout4;
  logic [3:0] a4, b4, sum4;
  logic [4:0] sb4[$];
  logic       done4 = 1'b0;

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n4), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4),
    .sum(sum4), .cout(cout4)
  );

  // ---------------- WIDTH = 1 ----------------
  logic       rst_n1, in_valid1, in_ready1, out_valid1, out_ready1, cin1, cout1;
  logic [0:0] a1, b1, sum1;
  logic [1:0] sb1[$];
  logic       done1 = 1'b0;

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n1), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1)
  );

  // Drive one operand set and take the accepting edge. The operands are
  // scrambled right after acceptance.
  task automatic send8(input logic [7:0] av, input logic [7:0] bv, input logic c);
    int cyc = 0;
    while (!in_ready && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    check("send8_in_ready", {31'd0, in_ready}, 32'd1);
    a = av; b = bv; cin = c; in_valid = 1'b1;
    @(posedge clk);
    sb8.push_back({1'b0, av} + {1'b0, bv} + {8'd0, c});
    #1;
    in_valid = 1'b0; a = ~av; b = ~bv; cin = ~c;
  endtask

  // Count edges from acceptance until out_valid rises (bounded).
  task automatic wait_out8(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
  endtask

  task automatic add8(input logic [7:0] av, input logic [7:0] bv, input logic c);
    int cyc;
    logic [8:0] exp;
    send8(av, bv, c);
    check("shift_in_ready", {31'd0, in_ready}, 32'd0);
    wait_out8(cyc);
    check("latency8", cyc, 8);
    if (out_valid && sb8.size() > 0) begin
      exp = sb8.pop_front();
      check($sformatf("sum8 %h+%h+%b", av, bv, c), {24'd0, sum}, {24'd0, exp[7:0]});
      check($sformatf("cout8 %h+%h+%b", av, bv, c), {31'd0, cout}, {31'd0, exp[8]});
      $display("add8 %h + %h + %b -> sum=%h cout=%b (exp %h)", av, bv, c, sum, cout, exp);
    end
    @(posedge clk); #1;
    check("post_out_valid", {31'd0, out_valid}, 32'd0);
    check("post_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  // Main WIDTH=8 sequence
  initial begin
    int cyc;
    logic saw;
    logic [8:0] exp;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;

    // 1: asynchronous reset, observed before any clock edge
    #2 rst_n = 1'b0;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_sum", {24'd0, sum}, 32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 2, 3
    add8(8'hFF, 8'h01, 1'b0);
    add8(8'hA5, 8'h5A, 1'b1);
    add8(8'h00, 8'h00, 1'b0);
    add8(8'h80, 8'h7F, 1'b1);

    // 4: backpressure
    out_ready = 1'b0;
    send8(8'h3C, 8'h0F, 1'b0);
    wait_out8(cyc);
    check("bp_latency", cyc, 8);
    in_valid = 1'b1; a = 8'h11; b = 8'h11;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_sum", {24'd0, sum}, 32'h4B);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    if (sb8.size() > 0) begin
      exp = sb8.pop_front();
      check("bp_sum_final", {24'd0, sum}, {24'd0, exp[7:0]});
      check("bp_cout_final", {31'd0, cout}, {31'd0, exp[8]});
      $display("add8 3c + 0f + 0 (backpressured) -> sum=%h cout=%b (exp %h)", sum, cout, exp);
    end
    @(posedge clk); #1;
    check("bp_idle_in_ready", {31'd0, in_ready}, 32'd1);
    check("bp_idle_sum_held", {24'd0, sum}, 32'h4B);
    saw = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid) saw = 1'b1;
    end
    check("bp_ignored_req", {31'd0, saw}, 32'd0);

    // 5: reset during the third SHIFT cycle
    send8(8'hAA, 8'h55, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_sum", {24'd0, sum}, 32'd0);
    sb8.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    saw = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) saw = 1'b1;
    end
    check("midrst_no_pulse", {31'd0, saw}, 32'd0);
    check("midrst_in_ready2", {31'd0, in_ready}, 32'd1);
    add8(8'h12, 8'h34, 1'b0);

    // Wait (bounded) for the exhaustive runs
    cyc = 0;
    while (!(done4 && done1) && cyc < 10000) begin
      @(posedge clk); cyc++;
    end
    check("exhaustive_done", {31'd0, done4 && done1}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // 6a: exhaustive WIDTH=4
  initial begin
    int cyc;
    logic [4:0] exp;
    rst_n4 = 1'b1; in_valid4 = 1'b0; out_ready4 = 1'b1; a4 = '0; b4 = '0; cin4 = 1'b0;
    #2 rst_n4 = 1'b0;
    @(posedge clk); #1 rst_n4 = 1'b1;
    for (int i = 0; i < 512; i++) begin
      {cin4, a4, b4} = 9'(i);
      in_valid4 = 1'b1;
      @(posedge clk);
      sb4.push_back({1'b0, a4} + {1'b0, b4} + {4'd0, cin4});
      #1 in_valid4 = 1'b0;
      cyc = 0;
      while (!out_valid4 && cyc < 10) begin
        @(posedge clk); #1; cyc++;
      end
      if (!out_valid4) begin
        check("w4_timeout", 32'd0, 32'd1);
      end else if (sb4.size() > 0) begin
        exp = sb4.pop_front();
        check($sformatf("w4_case%0d", i), {27'd0, cout4, sum4}, {27'd0, exp});
      end
      @(posedge clk); #1;
    end
    $display("w4 exhaustive: 512 adds compared");
    done4 = 1'b1;
  end

  // 6b: exhaustive WIDTH=1
  initial begin
    int cyc;
    logic [1:0] exp;
    rst_n1 = 1'b1; in_valid1 = 1'b0; out_ready1 = 1'b1; a1 = '0; b1 = '0; cin1 = 1'b0;
    #2 rst_n1 = 1'b0;
    @(posedge clk); #1 rst_n1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      {cin1, a1, b1} = 3'(i);
      in_valid1 = 1'b1;
      @(posedge clk);
      sb1.push_back({1'b0, a1} + {1'b0, b1} + {1'b0, cin1});
      #1 in_valid1 = 1'b0;
      cyc = 0;
      while (!out_valid1 && cyc < 10) begin
        @(posedge clk); #1; cyc++;
      end
      check($sformatf("w1_latency%0d", i), cyc, 1);
      if (out_valid1 && sb1.size() > 0) begin
        exp = sb1.pop_front();
        check($sformatf("w1_case%0d", i), {30'd0, cout1, sum1}, {30'd0, exp});
        $display("add1 %b + %b + %b -> sum=%b cout=%b", a1, b1, cin1, sum1, cout1);
      end
      @(posedge clk); #1;
    end
    done1 = 1'b1;
  end

endmodule : tb_serial_adder
